// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load-store.
// One outstanding transaction; a per-phase watchdog turns a stalled phase into an error response.
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_LS  = 1'b1;
    localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          wmask_q, wmask_d;
    logic [7:0]          wd_cnt_q, wd_cnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic                if_err_q, if_err_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                ls_err_q, ls_err_d;

    logic grant_if, grant_ls, wd_expired, resp_fire, resp_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= OWN_LS;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            wd_cnt_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wd_cnt_q    <= wd_cnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    // On a tie the side that was not granted last wins.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && (!ls_req || last_q == OWN_LS)) begin
                grant_if = 1'b1;
            end else if (ls_req) begin
                grant_ls = 1'b1;
            end
        end
        wd_expired = (state_q != IDLE) && (wd_cnt_q == WD_LAST);
    end

    // The exit event is checked before the watchdog so it wins a same-cycle race.
    always_comb begin
        state_d   = state_q;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_if || grant_ls) state_d = REQ;
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = RESP;
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d   = IDLE;
                    resp_fire = 1'b1;
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE || state_d != state_q) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
    end

    always_comb begin
        if_gnt  = grant_if;
        ls_gnt  = grant_ls;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (grant_if) begin
            last_d  = OWN_IF;
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            wmask_d = '0;
        end else if (grant_ls) begin
            last_d  = OWN_LS;
            owner_d = OWN_LS;
            we_d    = ls_we;
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            wmask_d = ls_wmask;
        end

        if_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_err_d    = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        if (resp_fire) begin
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_err_d    = resp_err;
                if (resp_err) begin
                    if_rdata_d = '0;
                end else begin
                    if_rdata_d = addr_q[2] ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
                end
            end else begin
                ls_rvalid_d = 1'b1;
                ls_err_d    = resp_err;
                ls_rdata_d  = resp_err ? '0 : mem_rdata;
            end
        end

        mem_req   = (state_q == REQ);
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? addr_q  : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        mem_wmask = mem_req ? wmask_q : '0;
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_err    = ls_err_q;

endmodule
